// File: rtl/ro_puf_pkg.sv
// Ring-oscillator PUF evaluation: shared types and width helpers.
//   state_t     - controller states
//   clog2_min1  - index width helper, never returns less than 1
//   max_int     - larger of two integers, used to size the phase timer
package ro_puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_MEASURE = 3'd2,
      ST_COMPARE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// One measurement channel: 2-FF synchronizer on an asynchronous oscillator
// output, rising-edge detect, and a saturating edge counter.
// Ports:
//   i_clk, i_rst_n  clock and synchronous active-low reset
//   i_ro            selected oscillator output (asynchronous to i_clk)
//   i_clr           hold the counter at zero (has priority over i_en)
//   i_en            count detected rising edges
//   o_cnt           current edge count
//   o_sat           edge arrived while the counter was already full
module ro_edge_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_ro,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_sat
);

   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic [CNT_W-1:0] r_cnt;
   logic             w_edge;
   logic             w_full;

   // r_s3 is the previous synchronized sample, so the edge is taken on
   // fully synchronized data only.
   assign w_edge = r_s2 & ~r_s3;
   assign w_full = &r_cnt;
   assign o_sat  = i_en & ~i_clr & w_edge & w_full;
   assign o_cnt  = r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_s3  <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1 <= i_ro;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (i_clr) begin
            r_cnt <= '0;
         end else if (i_en && w_edge && !w_full) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluation controller. For each response bit i it
// selects oscillators (chal_a+i) and (chal_b+i) mod NUM_RO, lets them settle,
// counts their rising edges over WINDOW clocks, and records count_a > count_b.
// Ports:
//   i_clk, i_rst_n      clock and synchronous active-low reset
//   i_start, i_abort    run request (IDLE only) and abort (highest priority)
//   i_chal_a, i_chal_b  base oscillator indices, latched on accepted start
//   i_ro_in             raw oscillator outputs
//   o_ro_en             oscillator enable
//   o_busy, o_done      not-IDLE indicator, one-cycle completion pulse
//   o_response          last completed response
//   o_cnt_a, o_cnt_b    counts of the most recently compared bit
//   o_tie_seen          an equal-count pair occurred in the last run
//   o_sat_seen          a counter saturated in the last run
//   o_bad_chal          last accepted challenge had chal_a == chal_b
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; oscillators off
// SETTLE  | oscillators on, counters held at 0, SETTLE cycles
// MEASURE | count edges for WINDOW cycles
// COMPARE | record one response bit, publish counts, advance bit index
// DONE    | response published, done pulse, back to IDLE
module ro_puf_eval
   import ro_puf_pkg::*;
#(
   parameter int NUM_RO    = 16,
   parameter int SEL_W     = 4,
   parameter int CNT_W     = 16,
   parameter int WINDOW    = 1024,
   parameter int SETTLE    = 16,
   parameter int RESP_BITS = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [SEL_W-1:0]     i_chal_a,
   input  logic [SEL_W-1:0]     i_chal_b,
   input  logic [NUM_RO-1:0]    i_ro_in,
   output logic                 o_ro_en,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [RESP_BITS-1:0] o_response,
   output logic [CNT_W-1:0]     o_cnt_a,
   output logic [CNT_W-1:0]     o_cnt_b,
   output logic                 o_tie_seen,
   output logic                 o_sat_seen,
   output logic                 o_bad_chal
);

   localparam int BIT_W = clog2_min1(RESP_BITS);
   localparam int TMR_W = clog2_min1(max_int(WINDOW, SETTLE));
   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
   localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(RESP_BITS - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [TMR_W-1:0]     r_timer;
   logic [BIT_W-1:0]     r_bit;
   logic [SEL_W-1:0]     r_chal_a;
   logic [SEL_W-1:0]     r_chal_b;
   logic [RESP_BITS-1:0] r_shadow;
   logic [RESP_BITS-1:0] r_response;
   logic [CNT_W-1:0]     r_cnt_a;
   logic [CNT_W-1:0]     r_cnt_b;
   logic                 r_tie_seen;
   logic                 r_sat_seen;
   logic                 r_bad_chal;

   logic                 w_accept;
   logic                 w_tmr_zero;
   logic                 w_last;
   logic                 w_cmp;
   logic [SEL_W-1:0]     w_idx_a;
   logic [SEL_W-1:0]     w_idx_b;
   logic                 w_ro_a;
   logic                 w_ro_b;
   logic                 w_cnt_clr;
   logic                 w_cnt_en;
   logic [CNT_W-1:0]     w_cnt_a;
   logic [CNT_W-1:0]     w_cnt_b;
   logic                 w_sat_a;
   logic                 w_sat_b;
   logic                 w_resp_bit;
   logic [RESP_BITS-1:0] w_shadow_nxt;

   assign w_tmr_zero = (r_timer == '0);
   assign w_last     = (r_bit == LAST_BIT);

   // Natural SEL_W-bit wrap of the sum gives the modulo-NUM_RO pair index.
   assign w_idx_a = r_chal_a + SEL_W'(r_bit);
   assign w_idx_b = r_chal_b + SEL_W'(r_bit);
   assign w_ro_a  = i_ro_in[w_idx_a];
   assign w_ro_b  = i_ro_in[w_idx_b];

   // Counts must survive into COMPARE, so only MEASURE and COMPARE keep them.
   assign w_cnt_clr = (r_state != ST_MEASURE) && (r_state != ST_COMPARE);
   assign w_cnt_en  = (r_state == ST_MEASURE);

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_ro    (w_ro_a),
      .i_clr   (w_cnt_clr),
      .i_en    (w_cnt_en),
      .o_cnt   (w_cnt_a),
      .o_sat   (w_sat_a)
   );

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_ro    (w_ro_b),
      .i_clr   (w_cnt_clr),
      .i_en    (w_cnt_en),
      .o_cnt   (w_cnt_b),
      .o_sat   (w_sat_b)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      o_ro_en     = 1'b0;
      o_busy      = 1'b1;
      o_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_busy = 1'b0;
            if (i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            o_ro_en = 1'b1;
            if (w_tmr_zero) begin
               w_state_nxt = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            o_ro_en = 1'b1;
            if (w_tmr_zero) begin
               w_state_nxt = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            o_ro_en     = 1'b1;
            w_state_nxt = w_last ? ST_DONE : ST_SETTLE;
         end
         ST_DONE: begin
            o_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (i_abort) begin
         w_accept    = 1'b0;
         w_state_nxt = ST_IDLE;
      end
   end

   // Phase down-counter: loaded on entry to SETTLE / MEASURE, leaves the
   // phase on the cycle it reads zero.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_timer <= '0;
      end else if (w_state_nxt == ST_SETTLE && r_state != ST_SETTLE) begin
         r_timer <= SETTLE_LD;
      end else if (w_state_nxt == ST_MEASURE && r_state != ST_MEASURE) begin
         r_timer <= WINDOW_LD;
      end else if (!w_tmr_zero) begin
         r_timer <= r_timer - 1'b1;
      end
   end

   assign w_cmp      = (r_state == ST_COMPARE) && !i_abort;
   assign w_resp_bit = !r_bad_chal && (w_cnt_a > w_cnt_b);

   always_comb begin
      w_shadow_nxt        = r_shadow;
      w_shadow_nxt[r_bit] = w_resp_bit;
   end

   // The response register is loaded together with the move into DONE so it
   // is already valid while done is high.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_chal_a   <= '0;
         r_chal_b   <= '0;
         r_bit      <= '0;
         r_shadow   <= '0;
         r_response <= '0;
         r_cnt_a    <= '0;
         r_cnt_b    <= '0;
         r_tie_seen <= 1'b0;
         r_sat_seen <= 1'b0;
         r_bad_chal <= 1'b0;
      end else if (w_accept) begin
         r_chal_a   <= i_chal_a;
         r_chal_b   <= i_chal_b;
         r_bit      <= '0;
         r_shadow   <= '0;
         r_tie_seen <= 1'b0;
         r_sat_seen <= 1'b0;
         r_bad_chal <= (i_chal_a == i_chal_b);
      end else begin
         if (w_sat_a || w_sat_b) begin
            r_sat_seen <= 1'b1;
         end
         if (w_cmp) begin
            r_shadow <= w_shadow_nxt;
            r_cnt_a  <= w_cnt_a;
            r_cnt_b  <= w_cnt_b;
            if (w_cnt_a == w_cnt_b) begin
               r_tie_seen <= 1'b1;
            end
            if (w_last) begin
               r_response <= w_shadow_nxt;
            end else begin
               r_bit <= r_bit + 1'b1;
            end
         end
      end
   end

   assign o_response = r_response;
   assign o_cnt_a    = r_cnt_a;
   assign o_cnt_b    = r_cnt_b;
   assign o_tie_seen = r_tie_seen;
   assign o_sat_seen = r_sat_seen;
   assign o_bad_chal = r_bad_chal;

endmodule

// File: tb/tb_ro_puf_eval.sv
// Directed bench for ro_puf_eval with small parameters. ro_in[k] is a square
// wave of period 2(k+1) clocks derived from the cycle counter, so edge counts
// and the response are known once the start cycle phase is fixed.
module tb_ro_puf_eval;

   localparam int LAT = 53;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       start2 = 1'b0;
   logic       abort = 1'b0;
   logic [2:0] chal_a = '0;
   logic [2:0] chal_b = '0;
   logic [7:0] ro_in = '0;

   logic       ro_en, busy, done, tie_seen, sat_seen, bad_chal;
   logic [3:0] response, cnt_a, cnt_b;
   logic       s_ro_en, s_busy, s_done, s_tie_seen, s_sat_seen, s_bad_chal;
   logic [3:0] s_response;
   logic [1:0] s_cnt_a, s_cnt_b;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   ro_puf_eval #(.NUM_RO(8), .SEL_W(3), .CNT_W(4), .WINDOW(8), .SETTLE(4),
                 .RESP_BITS(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
      .i_chal_a(chal_a), .i_chal_b(chal_b), .i_ro_in(ro_in),
      .o_ro_en(ro_en), .o_busy(busy), .o_done(done), .o_response(response),
      .o_cnt_a(cnt_a), .o_cnt_b(cnt_b), .o_tie_seen(tie_seen),
      .o_sat_seen(sat_seen), .o_bad_chal(bad_chal));

   ro_puf_eval #(.NUM_RO(8), .SEL_W(3), .CNT_W(2), .WINDOW(8), .SETTLE(4),
                 .RESP_BITS(4)) dut_sat (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_abort(1'b0),
      .i_chal_a(chal_a), .i_chal_b(chal_b), .i_ro_in(ro_in),
      .o_ro_en(s_ro_en), .o_busy(s_busy), .o_done(s_done),
      .o_response(s_response), .o_cnt_a(s_cnt_a), .o_cnt_b(s_cnt_b),
      .o_tie_seen(s_tie_seen), .o_sat_seen(s_sat_seen),
      .o_bad_chal(s_bad_chal));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      for (int k = 0; k < 8; k++) ro_in[k] = (((cyc / (k + 1)) % 2) == 1);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ro_en"}, ro_en, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_resp"}, response, 0);
      chk({tag, "_cnt_a"}, cnt_a, 0);
      chk({tag, "_cnt_b"}, cnt_b, 0);
      chk({tag, "_tie"}, tie_seen, 0);
      chk({tag, "_sat"}, sat_seen, 0);
      chk({tag, "_bad"}, bad_chal, 0);
   endtask

   typedef struct {
      string      name;
      logic [2:0] a, b;
      int         md, rs;       // start when cyc % md == rs (oscillator phase)
      logic [3:0] resp;
      logic       tie, bad;
      logic       chk0;         // check counts of bit 0
      logic [3:0] c0a, c0b;
      logic       chkf;         // check counts of the last bit
      logic [3:0] cfa, cfb;
   } vec_t;

   vec_t vecs[3];

   task automatic run_one(input vec_t v);
      int d;
      @(negedge clk);
      while ((cyc % v.md) != v.rs) @(negedge clk);
      chal_a = v.a; chal_b = v.b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; chal_a = '0; chal_b = '0;
      chk({v.name, "_busy"}, busy, 1);
      d = 1;
      while (!done && d < 200) begin
         if (d == 20 && v.chk0) begin
            chk({v.name, "_cnt0_a"}, cnt_a, v.c0a);
            chk({v.name, "_cnt0_b"}, cnt_b, v.c0b);
         end
         @(negedge clk);
         d++;
      end
      chk({v.name, "_latency"}, done ? d : 0, LAT);
      if (done) begin
         @(negedge clk);
         chk({v.name, "_done_1cyc"}, done, 0);
         chk({v.name, "_idle"}, busy, 0);
         chk({v.name, "_resp"}, response, v.resp);
         chk({v.name, "_tie"}, tie_seen, v.tie);
         chk({v.name, "_sat"}, sat_seen, 0);
         chk({v.name, "_bad"}, bad_chal, v.bad);
         if (v.chkf) begin
            chk({v.name, "_cntf_a"}, cnt_a, v.cfa);
            chk({v.name, "_cntf_b"}, cnt_b, v.cfb);
         end
      end
   endtask

   initial begin
      int ndone;
      int d;
      vecs[0] = '{"tie_bad", 3'd3, 3'd3, 1, 0, 4'b0000, 1'b1, 1'b1,
                  1'b1, 4'd1, 4'd1, 1'b0, 4'd0, 4'd0};
      vecs[1] = '{"basic", 3'd0, 3'd1, 30, 15, 4'b1111, 1'b0, 1'b0,
                  1'b1, 4'd4, 4'd2, 1'b1, 4'd1, 4'd0};
      vecs[2] = '{"wrap", 3'd7, 3'd0, 6, 2, 4'b1110, 1'b0, 1'b0,
                  1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 4'd1};

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) run_one(vecs[i]);

      // start and abort together in IDLE: abort wins
      @(negedge clk);
      chal_a = 3'd0; chal_b = 3'd1; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", busy, 0);
      chk("start_abort_ro_en", ro_en, 0);

      // abort mid-run, with an ignored start while busy
      @(negedge clk);
      chal_a = 3'd0; chal_b = 3'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chal_a = 3'd5; chal_b = 3'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("abort_pre_ro_en", ro_en, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_ro_en", ro_en, 0);
      chk("abort_resp", response, 4'b1110);
      chk("busy_start_ignored", bad_chal, 0);
      ndone = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      chk("abort_no_done", ndone, 0);

      // reset mid-run
      @(negedge clk);
      chal_a = 3'd2; chal_b = 3'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      chk("pre_reset_bad", bad_chal, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk_all_zero("midrst");
      rst_n = 1'b1;
      run_one(vecs[1]);

      // saturation on the narrow-counter instance
      @(negedge clk);
      chal_a = 3'd0; chal_b = 3'd2; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      d = 1;
      while (!s_done && d < 200) begin
         if (d == 20) begin
            chk("sat_cnt_a", s_cnt_a, 3);
            chk("sat_seen_bit0", s_sat_seen, 1);
         end
         @(negedge clk);
         d++;
      end
      chk("sat_latency", s_done ? d : 0, LAT);
      @(negedge clk);
      chk("sat_resp0", s_response[0], 1);
      chk("sat_seen", s_sat_seen, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
